// File: rtl/btb_if.sv
// Fetch/execute-side signal bundle for the branch target buffer.
// The master side drives lookup and training inputs; the slave side is the BTB itself.
interface btb_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush_all;
  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] ras_top;
  logic            ras_valid;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            pred_call;
  logic            pred_return;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_target;
  logic            upd_taken;
  logic [1:0]      upd_type;

  modport master (
    output flush_all, pc_f, ras_top, ras_valid,
    output upd_valid, upd_pc, upd_target, upd_taken, upd_type,
    input  pred_taken, pred_target, pred_call, pred_return
  );

  modport slave (
    input  flush_all, pc_f, ras_top, ras_valid,
    input  upd_valid, upd_pc, upd_target, upd_taken, upd_type,
    output pred_taken, pred_target, pred_call, pred_return
  );
endinterface

// File: rtl/btb.sv
// Direct-mapped tagged branch target buffer with 2-bit direction counters.
// Combinational next-PC lookup; RAS top used for return prediction.
module btb #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned XLEN    = 32
) (
  input logic  clk,
  input logic  reset_n,
  btb_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  typedef enum logic [1:0] {
    BR_COND = 2'b00,
    BR_JUMP = 2'b01,
    BR_CALL = 2'b10,
    BR_RET  = 2'b11
  } br_type_e;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];
  br_type_e         type_q  [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic [XLEN-1:0]  pc_plus4;

  logic             wr_en;
  br_type_e         wr_type;
  logic [1:0]       wr_ctr;
  logic             unused_pc_lsbs;

  assign lk_idx   = bus.pc_f[IDX_W+1:2];
  assign lk_tag   = bus.pc_f[XLEN-1:IDX_W+2];
  assign up_idx   = bus.upd_pc[IDX_W+1:2];
  assign up_tag   = bus.upd_pc[XLEN-1:IDX_W+2];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign pc_plus4 = bus.pc_f + XLEN'(4);
  assign unused_pc_lsbs = ^{bus.pc_f[1:0], bus.upd_pc[1:0]};

  always_comb begin
    bus.pred_taken  = 1'b0;
    bus.pred_target = pc_plus4;
    bus.pred_call   = 1'b0;
    bus.pred_return = 1'b0;
    if (lk_hit) begin
      bus.pred_call   = (type_q[lk_idx] == BR_CALL);
      bus.pred_return = (type_q[lk_idx] == BR_RET);
      bus.pred_taken  = (type_q[lk_idx] != BR_COND) || ctr_q[lk_idx][1];
      if (bus.pred_taken) begin
        if ((type_q[lk_idx] == BR_RET) && bus.ras_valid)
          bus.pred_target = bus.ras_top;
        else
          bus.pred_target = tgt_q[lk_idx];
      end
    end
  end

  // Hits always retrain; misses only allocate when the branch was taken.
  always_comb begin
    wr_en   = 1'b0;
    wr_type = br_type_e'(bus.upd_type);
    wr_ctr  = 2'b11;
    if (bus.upd_valid) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (wr_type == BR_COND) begin
          if (bus.upd_taken)
            wr_ctr = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'b01;
          else
            wr_ctr = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'b01;
        end
      end else if (bus.upd_taken) begin
        wr_en  = 1'b1;
        wr_ctr = (wr_type == BR_COND) ? 2'b10 : 2'b11;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        type_q[i]  <= BR_COND;
        ctr_q[i]   <= 2'b01;
      end
    end else if (bus.flush_all) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (wr_en) begin
      valid_q[up_idx] <= 1'b1;
      tag_q[up_idx]   <= up_tag;
      tgt_q[up_idx]   <= bus.upd_target;
      type_q[up_idx]  <= wr_type;
      ctr_q[up_idx]   <= wr_ctr;
    end
  end
endmodule

// File: tb/tb_btb.sv
// Directed self-checking bench for the btb next-PC predictor.
module tb_btb;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  btb_if #(.XLEN(32)) bus ();

  btb #(.ENTRIES(16), .XLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                     input logic taken, input logic [1:0] ty);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_target = tgt;
    bus.upd_taken  = taken;
    bus.upd_type   = ty;
    @(posedge clk);
    #1;
    bus.upd_valid  = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic taken, input logic [31:0] tgt);
    bus.pc_f = pc;
    #1;
    check({tag, ".taken"}, {31'b0, bus.pred_taken}, {31'b0, taken});
    check({tag, ".target"}, bus.pred_target, tgt);
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset_n        = 1'b0;
    bus.flush_all  = 1'b0;
    bus.pc_f       = 32'h100;
    bus.ras_top    = '0;
    bus.ras_valid  = 1'b0;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_target = '0;
    bus.upd_taken  = 1'b0;
    bus.upd_type   = 2'b00;
    #12;
    check("rst.taken",  {31'b0, bus.pred_taken},  32'd0);
    check("rst.target", bus.pred_target,          32'h104);
    check("rst.call",   {31'b0, bus.pred_call},   32'd0);
    check("rst.return", {31'b0, bus.pred_return}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    look("post_rst", 32'h100, 1'b0, 32'h104);

    // Conditional branch counter walk: alloc 10, 01, 00, then 01.
    upd(32'h100, 32'h200, 1'b1, 2'b00);
    look("cond.alloc", 32'h100, 1'b1, 32'h200);
    upd(32'h100, 32'h200, 1'b0, 2'b00);
    look("cond.nt1", 32'h100, 1'b0, 32'h104);
    upd(32'h100, 32'h200, 1'b0, 2'b00);
    look("cond.nt2", 32'h100, 1'b0, 32'h104);
    upd(32'h100, 32'h200, 1'b1, 2'b00);
    look("cond.t_from0", 32'h100, 1'b0, 32'h104);

    // Call, then return at an aliasing index.
    upd(32'h40, 32'h800, 1'b1, 2'b10);
    look("call", 32'h40, 1'b1, 32'h800);
    check("call.call", {31'b0, bus.pred_call},   32'd1);
    check("call.ret",  {31'b0, bus.pred_return}, 32'd0);
    upd(32'h840, 32'h0, 1'b1, 2'b11);
    bus.ras_valid = 1'b1;
    bus.ras_top   = 32'h44;
    look("ret.ras", 32'h840, 1'b1, 32'h44);
    check("ret.ret",  {31'b0, bus.pred_return}, 32'd1);
    check("ret.call", {31'b0, bus.pred_call},   32'd0);
    bus.ras_valid = 1'b0;
    look("ret.noras", 32'h840, 1'b1, 32'h0);
    check("ret.noras.ret", {31'b0, bus.pred_return}, 32'd1);
    look("call.evicted", 32'h40, 1'b0, 32'h44);

    // Aliasing: same index, different tag replaces the occupant.
    upd(32'h100, 32'h300, 1'b1, 2'b01);
    look("alias.first", 32'h100, 1'b1, 32'h300);
    upd(32'h140, 32'h500, 1'b1, 2'b01);
    look("alias.old", 32'h100, 1'b0, 32'h104);
    look("alias.new", 32'h140, 1'b1, 32'h500);

    // Not-taken miss leaves the table untouched.
    upd(32'h180, 32'h900, 1'b0, 2'b00);
    look("nt_miss", 32'h180, 1'b0, 32'h184);
    look("nt_miss.keep", 32'h140, 1'b1, 32'h500);

    // Counter saturation at 11.
    upd(32'h10, 32'h600, 1'b1, 2'b00);
    upd(32'h10, 32'h600, 1'b1, 2'b00);
    upd(32'h10, 32'h600, 1'b1, 2'b00);
    upd(32'h10, 32'h600, 1'b0, 2'b00);
    look("sat.nt1", 32'h10, 1'b1, 32'h600);
    upd(32'h10, 32'h600, 1'b0, 2'b00);
    look("sat.nt2", 32'h10, 1'b0, 32'h14);

    // Flush wins over a same-cycle allocate.
    bus.flush_all = 1'b1;
    upd(32'h200, 32'hA00, 1'b1, 2'b01);
    bus.flush_all = 1'b0;
    look("flush.alloc", 32'h200, 1'b0, 32'h204);
    look("flush.old",   32'h140, 1'b0, 32'h144);

    // Lookup during an update to the same entry sees the old contents.
    upd(32'h300, 32'h900, 1'b1, 2'b01);
    bus.pc_f       = 32'h300;
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 32'h300;
    bus.upd_target = 32'hB00;
    bus.upd_taken  = 1'b1;
    bus.upd_type   = 2'b01;
    #1;
    check("same_cyc.old", bus.pred_target, 32'h900);
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    look("same_cyc.new", 32'h300, 1'b1, 32'hB00);

    // PC+4 wraps modulo 2^32.
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Reset during an update discards it and clears the table.
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 32'h20;
    bus.upd_target = 32'h700;
    bus.upd_taken  = 1'b1;
    bus.upd_type   = 2'b01;
    #2;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    look("rst_mid.upd", 32'h20,  1'b0, 32'h24);
    look("rst_mid.old", 32'h300, 1'b0, 32'h304);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
